// File: rtl/bit_count_iter.sv
// ============================================================================
//  Module      : bit_count_iter
//  Description : Iterative CLZ / CTZ / CPOP unit with a valid/ready handshake
//                on both sides, one shift-and-test step per clock.
//                Optional macro BC_NIBBLE_SKIP_EN: CLZ/CTZ skip four zero
//                bits per step when the top nibble is clear.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_count_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       bc_op,
    input  logic [XLEN-1:0]  bc_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  bc_out
);

    localparam logic [3:0]       c_op_clz  = 4'b1100;
    localparam logic [3:0]       c_op_ctz  = 4'b1101;
    localparam logic [3:0]       c_op_cpop = 4'b1110;
    localparam logic [CNT_W-1:0] c_full    = CNT_W'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op_q;
    logic [4:0]        r_step;
    logic [CNT_W-1:0]  r_result;
    logic              r_out_valid;
    logic              r_busy;
    logic [XLEN-1:0]   w_rev;

    // CTZ is turned into CLZ by reversing the operand at accept time.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_rev
            assign w_rev[gi] = bc_in[XLEN-1-gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_op_q      <= '0;
            r_step      <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sr    <= (bc_op == c_op_ctz) ? w_rev : bc_in;
                        r_cnt   <= '0;
                        r_step  <= '0;
                        r_op_q  <= bc_op;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_op_q == c_op_clz || r_op_q == c_op_ctz) begin
                        if (r_sr[XLEN-1]) begin
                            r_result    <= r_cnt;
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
`ifdef BC_NIBBLE_SKIP_EN
                        end else if (r_sr[XLEN-1 -: 4] == 4'd0 && r_cnt <= CNT_W'(XLEN-4)) begin
                            r_sr  <= r_sr << 4;
                            r_cnt <= r_cnt + CNT_W'(4);
                            // Skipping the last nibble means the word was all zeros.
                            if (r_cnt == CNT_W'(XLEN-4)) begin
                                r_result    <= c_full;
                                r_state     <= S_DONE;
                                r_out_valid <= 1'b1;
                            end
`endif
                        end else if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_result    <= c_full;
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_sr  <= r_sr << 1;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (r_op_q == c_op_cpop) begin
                        r_sr   <= r_sr << 1;
                        r_cnt  <= r_cnt + CNT_W'(r_sr[XLEN-1]);
                        r_step <= r_step + 5'd1;
                        if (r_step == 5'd31) begin
                            r_result    <= r_cnt + CNT_W'(r_sr[XLEN-1]);
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_result    <= '0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rst_n & (r_state == S_IDLE);
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign bc_out    = {{(XLEN-CNT_W){1'b0}}, r_result};

endmodule

`default_nettype wire

// File: tb/tb_bit_count_iter.sv
// ============================================================================
//  Module      : tb_bit_count_iter
//  Description : Self-checking bench for bit_count_iter against a behavioural
//                count/latency model; honours BC_NIBBLE_SKIP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_count_iter;

    localparam logic [3:0] c_clz  = 4'b1100;
    localparam logic [3:0] c_ctz  = 4'b1101;
    localparam logic [3:0] c_cpop = 4'b1110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  bc_op = 4'd0;
    logic [31:0] bc_in = 32'd0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] bc_out;

    int n_checks = 0;
    int n_pass   = 0;

    bit_count_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bc_op     (bc_op),
        .bc_in     (bc_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bc_out    (bc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, obs, obs, exp, exp);
    endtask

    function automatic int ref_result(input logic [3:0] op, input logic [31:0] x);
        int n;
        n = 0;
        if (op == c_clz) begin
            while (n < 32 && x[31-n] == 1'b0) n++;
        end else if (op == c_ctz) begin
            while (n < 32 && x[n] == 1'b0) n++;
        end else if (op == c_cpop) begin
            for (int i = 0; i < 32; i++) n += int'(x[i]);
        end
        return n;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] x);
        int k;
        if (op == c_cpop) return 32;
        if (op != c_clz && op != c_ctz) return 1;
        k = ref_result(op, x);
`ifdef BC_NIBBLE_SKIP_EN
        if (k == 32) return 8;
        return k / 4 + k % 4 + 1;
`else
        if (k == 32) return 32;
        return k + 1;
`endif
    endfunction

    // Issue one op, measure edges to out_valid, optionally stall in DONE.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input int hold);
        int edges;
        logic [31:0] er;
        er = 32'(ref_result(op, x));
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        bc_op = op; bc_in = x; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 32'(edges), 32'(ref_latency(op, x)));
        chk("result", bc_out, er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = i[0];
            bc_in = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", bc_out, er);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_keeps_result", bc_out, er);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bc_out", bc_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(c_clz,  32'h0001_0000, 0);
        run_op(c_ctz,  32'h8000_0000, 0);
        run_op(c_ctz,  32'h0000_0001, 0);
        run_op(c_clz,  32'h0000_0000, 0);
        run_op(c_ctz,  32'h0000_0000, 0);
        run_op(c_cpop, 32'h0000_0000, 0);
        run_op(c_cpop, 32'hF0F0_F0F1, 0);
        run_op(c_clz,  32'h8000_0000, 10);
        run_op(4'b0011, 32'hFFFF_FFFF, 0);
        run_op(c_clz,  32'h0000_0001, 0);

        // Abort a CLZ mid-run with an asynchronous reset.
        @(negedge clk);
        bc_op = c_clz; bc_in = 32'h0000_0100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_bc_out", bc_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(c_clz, 32'h8000_0000, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: op = c_clz;
                1: op = c_ctz;
                2: op = c_cpop;
                default: op = 4'($urandom_range(0, 11));
            endcase
            x = $urandom;
            if ($urandom_range(0, 1) == 1) x = x >> $urandom_range(0, 31);
            else x = x << $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) x = 32'd0;
            run_op(op, x, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bit_count_iter.md
Name: bit_count_iter

Overview:
- Multi-cycle bit-scan unit for the Zbb-style count ops: CLZ (count leading zeros), CTZ (count trailing zeros) and CPOP (population count).
- Works in the opposite direction to the shift datapath: instead of applying a shift amount to a word, it finds how far the word must shift to reach its first set bit.
- Iterative: one shift-and-test step per cycle. Valid/ready handshake on both input and output.
- Sits beside the ALU/shifter. The core stalls on busy.

Parameters:
- XLEN, 32, operand width. Only 32 is supported.
- CNT_W, 6, count/result counter width; holds 0..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand and op are presented
- in_ready  output  1  unit can accept an operand (IDLE state)
- bc_op  input  4  op select: 4'b1100 = CLZ, 4'b1101 = CTZ, 4'b1110 = CPOP; any other code is unsupported
- bc_in  input  32  operand
- busy  output  1  state is RUN or DONE
- out_valid  output  1  result is available
- out_ready  input  1  consumer accepts the result
- bc_out  output  32  result, zero-extended from CNT_W bits

Behaviour:
- Reset (async, rst_n low):
  - state goes to IDLE; sr, cnt and op_q clear to 0.
  - out_valid=0, bc_out=0, busy=0.
  - in_ready is forced 0 while rst_n is low.
  - A reset during RUN or DONE abandons the operation; no output is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready (the accept edge):
    - sr <= bc_in for CLZ/CPOP; sr <= bit-reverse(bc_in) for CTZ.
    - cnt <= 0; op_q <= bc_op; next state RUN.
- RUN, CLZ/CTZ, evaluated each clock edge in priority order:
  1. sr[31]=1: go to DONE, result = cnt.
  2. Else cnt=31: go to DONE, result = 32.
  3. Else: sr <= sr<<1, cnt <= cnt+1.
- RUN, CPOP:
  - Each edge: cnt <= cnt + sr[31], sr <= sr<<1.
  - After 32 steps, go to DONE with result = cnt.
  - A separate 5-bit step counter is used.
- RUN, unsupported op: go to DONE after 1 edge with result = 0.
- Latency, counted in edges from the accept edge to out_valid rising:
  - CLZ/CTZ with k leading/trailing zeros (k<32): k+1.
  - Zero operand: 32.
  - CPOP: 32.
  - Unsupported op: 1.
- DONE:
  - out_valid=1; bc_out holds the result stable.
  - On out_ready, the next edge goes to IDLE and out_valid drops.
  - The result holds indefinitely while out_ready=0.
- in_valid in RUN or DONE is ignored (in_ready=0). There is no back-to-back accept: at least one IDLE cycle separates operations.
- bc_out is registered; it updates only on entry to DONE and keeps its value in IDLE until the next DONE.

Optional Feature:
- Macro: BC_NIBBLE_SKIP_EN.
- Defined:
  - CLZ/CTZ adds a rule between rules 1 and 2: if sr[31:28]=0 and cnt<=28, then sr <= sr<<4 and cnt <= cnt+4.
  - If the new cnt equals 32, go to DONE with result 32.
  - Latency for k<32 becomes floor(k/4)+(k mod 4)+1 edges; a zero operand takes 8 edges.
  - CPOP is unchanged.
- Undefined: single-bit stepping only, with the latencies above.
- Result values are identical either way.

Test Plan:
- CLZ of 32'h0001_0000 -> bc_out=15; out_valid 16 edges after accept (default build), 7 edges with BC_NIBBLE_SKIP_EN.
- CTZ of 32'h8000_0000 -> 31 after 32 edges; CTZ of 32'h0000_0001 -> 0 after 1 edge.
- CLZ/CTZ/CPOP of 32'h0 -> 32 / 32 / 0. CPOP of 32'hF0F0_F0F1 -> 17 after 32 edges.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and bc_out stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
- Pull rst_n low at RUN step 5 of CLZ(32'h0000_0100) -> out_valid=0, busy=0 immediately; after release, a new CLZ(32'h8000_0000) returns 0 in 1 edge.
- bc_op=4'b0011 with bc_in=32'hFFFF_FFFF -> bc_out=0, out_valid after 1 edge.
